// File: rtl/jp_io_sequencer_if.sv
// jp_io_sequencer_if: decoder strobe, operand fetch, PC, I/O and A-load signals of the sequencer.
// master = sequencer side: takes start/class/cc/flags/reg_a and the acks, and drives requests and pulses.
// slave  = environment side: decoder, memory, PC, I/O bus and register file.
interface jp_io_sequencer_if;
    logic        start;
    logic        set_jpnn;
    logic        set_jpcc;
    logic        set_out_n_a;
    logic        set_in_a_n;
    logic [2:0]  cc;
    logic [7:0]  flags;
    logic [7:0]  reg_a;
    logic        mem_req;
    logic        mem_ack;
    logic [7:0]  mem_data;
    logic        pc_inc;
    logic        pc_load;
    logic [15:0] pc_value;
    logic        io_req;
    logic        io_wr;
    logic [15:0] io_addr;
    logic [7:0]  io_wdata;
    logic        io_ack;
    logic [7:0]  io_rdata;
    logic        a_load;
    logic [7:0]  a_value;
    logic        busy;
    logic        done;

    modport master (
        input  start, set_jpnn, set_jpcc, set_out_n_a, set_in_a_n, cc, flags, reg_a,
        input  mem_ack, mem_data, io_ack, io_rdata,
        output mem_req, pc_inc, pc_load, pc_value, io_req, io_wr, io_addr, io_wdata,
        output a_load, a_value, busy, done
    );

    modport slave (
        output start, set_jpnn, set_jpcc, set_out_n_a, set_in_a_n, cc, flags, reg_a,
        output mem_ack, mem_data, io_ack, io_rdata,
        input  mem_req, pc_inc, pc_load, pc_value, io_req, io_wr, io_addr, io_wdata,
        input  a_load, a_value, busy, done
    );
endinterface

// File: rtl/jp_io_sequencer.sv
// jp_io_sequencer: sequences JP nn / JP cc,nn / OUT (n),A / IN A,(n) operand fetch, jump and I/O cycles.
// Ports: clk, reset (async, active-high), bus (jp_io_sequencer_if.master).
module jp_io_sequencer (
    input logic clk,
    input logic reset,
    jp_io_sequencer_if.master bus
);
    typedef enum logic [2:0] {IDLE, FETCH_LO, FETCH_HI, FETCH_N, IO, FINISH} state_t;
    state_t state;
    logic uncond, is_out, sel, cond;
    logic [2:0] cc_q;
    logic [7:0] lo;
    // cc[2:1] picks the flag (Z, C, P/V, S); cc[0] is the value that makes the condition true.
    always_comb begin
        sel = cc_q[2] ? (cc_q[1] ? bus.flags[7] : bus.flags[2]) : (cc_q[1] ? bus.flags[0] : bus.flags[6]);
        cond = uncond | (sel == cc_q[0]);
    end
    // mem_req is only ever high in fetch states, so this also gates off stray acks.
    assign bus.pc_inc = bus.mem_req & bus.mem_ack;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            uncond <= 1'b0;
            is_out <= 1'b0;
            cc_q <= '0;
            lo <= '0;
            bus.mem_req <= 1'b0;
            bus.io_req <= 1'b0;
            bus.io_wr <= 1'b0;
            bus.pc_load <= 1'b0;
            bus.a_load <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.pc_value <= '0;
            bus.io_addr <= '0;
            bus.io_wdata <= '0;
            bus.a_value <= '0;
        end else begin
            bus.pc_load <= 1'b0;
            bus.a_load <= 1'b0;
            bus.done <= 1'b0;
            case (state)
                IDLE: if (bus.start && $onehot({bus.set_jpnn, bus.set_jpcc, bus.set_out_n_a, bus.set_in_a_n})) begin
                    uncond <= bus.set_jpnn;
                    is_out <= bus.set_out_n_a;
                    cc_q <= bus.cc;
                    bus.io_wdata <= bus.reg_a;
                    bus.mem_req <= 1'b1;
                    bus.busy <= 1'b1;
                    state <= (bus.set_jpnn || bus.set_jpcc) ? FETCH_LO : FETCH_N;
                end
                FETCH_LO: if (bus.mem_ack) begin
                    lo <= bus.mem_data;
                    state <= FETCH_HI;
                end
                FETCH_HI: if (bus.mem_ack) begin
                    bus.mem_req <= 1'b0;
                    bus.pc_value <= {bus.mem_data, lo};
                    bus.pc_load <= cond;
                    bus.done <= 1'b1;
                    state <= FINISH;
                end
                FETCH_N: if (bus.mem_ack) begin
                    bus.mem_req <= 1'b0;
                    bus.io_req <= 1'b1;
                    bus.io_wr <= is_out;
                    bus.io_addr <= {bus.io_wdata, bus.mem_data};
                    state <= IO;
                end
                IO: if (bus.io_ack) begin
                    bus.io_req <= 1'b0;
                    bus.io_wr <= 1'b0;
                    if (!is_out) begin
                        bus.a_value <= bus.io_rdata;
                        bus.a_load <= 1'b1;
                    end
                    bus.done <= 1'b1;
                    state <= FINISH;
                end
                FINISH: begin
                    bus.busy <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_jp_io_sequencer.sv
// tb_jp_io_sequencer: directed scoreboard bench for jp_io_sequencer.
module tb_jp_io_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    jp_io_sequencer_if bus();
    jp_io_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

    localparam logic [3:0] EV_INC = 4'd1, EV_LOAD = 4'd2, EV_ALOAD = 4'd3, EV_DONE = 4'd4, EV_IO = 4'd5;

    int passed = 0, total = 0, cyc = 0, done_cyc = 0, start_cyc = 0;
    logic [63:0] sb[$];
    logic io_req_d = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] ev(input logic [3:0] k, input logic [31:0] d);
        return {28'd0, k, d};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic sb_check(input string tag, input logic [63:0] obs);
        if (sb.size() == 0) begin
            total++;
            $error("FAIL %s unexpected event observed=%h expected=none", tag, obs);
        end else check(tag, obs, sb.pop_front());
    endtask

    always @(negedge clk) if (!reset) begin
        if (bus.pc_inc) sb_check("pc_inc", ev(EV_INC, 32'd0));
        if (bus.io_req && !io_req_d) sb_check("io_start", ev(EV_IO, {7'd0, bus.io_wr, bus.io_addr, bus.io_wdata}));
        if (bus.pc_load) sb_check("pc_load", ev(EV_LOAD, {16'd0, bus.pc_value}));
        if (bus.a_load) sb_check("a_load", ev(EV_ALOAD, {24'd0, bus.a_value}));
        if (bus.done) begin
            done_cyc <= cyc;
            sb_check("done", ev(EV_DONE, 32'd0));
        end
        check("mem_io_exclusive", {63'd0, bus.mem_req & bus.io_req}, 64'd0);
        check("load_inc_exclusive", {63'd0, bus.pc_load & bus.pc_inc}, 64'd0);
        io_req_d <= bus.io_req;
    end

    function automatic logic [63:0] all_outs();
        return {8'd0, bus.mem_req, bus.io_req, bus.io_wr, bus.pc_inc, bus.pc_load, bus.a_load, bus.busy, bus.done,
                bus.pc_value, bus.io_addr, bus.io_wdata, bus.a_value};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] cls, input logic [2:0] c, input logic [7:0] a, input logic [7:0] f);
        {bus.set_jpnn, bus.set_jpcc, bus.set_out_n_a, bus.set_in_a_n} = cls;
        bus.start = 1'b1;
        bus.cc = c;
        bus.reg_a = a;
        bus.flags = f;
        start_cyc = cyc;
        tick;
        bus.start = 1'b0;
        {bus.set_jpnn, bus.set_jpcc, bus.set_out_n_a, bus.set_in_a_n} = 4'b0000;
        bus.cc = ~c;
        bus.reg_a = ~a;
    endtask

    task automatic mem_byte(input logic [7:0] b, input int waits);
        repeat (waits) begin
            check("mem_req_wait", {63'd0, bus.mem_req}, 64'd1);
            tick;
        end
        bus.mem_ack = 1'b1;
        bus.mem_data = b;
        check("mem_req", {63'd0, bus.mem_req}, 64'd1);
        tick;
        bus.mem_ack = 1'b0;
        bus.mem_data = 8'($urandom);
    endtask

    task automatic do_jp(input logic nn, input logic [2:0] c, input logic [7:0] f, input logic [7:0] lo,
                         input logic [7:0] hi, input int w, input logic exp_load, input logic poke);
        sb.push_back(ev(EV_INC, 32'd0));
        sb.push_back(ev(EV_INC, 32'd0));
        if (exp_load) sb.push_back(ev(EV_LOAD, {16'd0, hi, lo}));
        sb.push_back(ev(EV_DONE, 32'd0));
        issue(nn ? 4'b1000 : 4'b0100, c, 8'($urandom), ~f);
        mem_byte(lo, w);
        bus.flags = f;
        if (poke) begin
            bus.start = 1'b1;
            bus.set_out_n_a = 1'b1;
        end
        mem_byte(hi, w);
        bus.start = 1'b0;
        bus.set_out_n_a = 1'b0;
        tick;
        check("jp_busy_idle", {63'd0, bus.busy}, 64'd0);
        check("jp_latency", 64'(done_cyc - start_cyc), 64'(3 + 2 * w));
        check("jp_sb_drained", 64'(sb.size()), 64'd0);
    endtask

    task automatic do_io(input logic out, input logic [7:0] a, input logic [7:0] n, input logic [7:0] rd, input int w);
        sb.push_back(ev(EV_INC, 32'd0));
        sb.push_back(ev(EV_IO, {7'd0, out, a, n, a}));
        if (!out) sb.push_back(ev(EV_ALOAD, {24'd0, rd}));
        sb.push_back(ev(EV_DONE, 32'd0));
        issue(out ? 4'b0010 : 4'b0001, 3'd0, a, 8'($urandom));
        mem_byte(n, 0);
        repeat (w) begin
            check("io_hold", {39'd0, bus.io_req, bus.io_wr, bus.io_addr, bus.io_wdata}, {39'd0, 1'b1, out, a, n, a});
            tick;
        end
        bus.io_ack = 1'b1;
        bus.io_rdata = rd;
        check("io_hold", {39'd0, bus.io_req, bus.io_wr, bus.io_addr, bus.io_wdata}, {39'd0, 1'b1, out, a, n, a});
        tick;
        bus.io_ack = 1'b0;
        bus.io_rdata = 8'($urandom);
        check("io_req_dropped", {63'd0, bus.io_req}, 64'd0);
        tick;
        check("io_busy_idle", {63'd0, bus.busy}, 64'd0);
        check("io_sb_drained", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        logic exp;
        logic [7:0] f;
        bus.start = 1'b0;
        {bus.set_jpnn, bus.set_jpcc, bus.set_out_n_a, bus.set_in_a_n} = 4'b0000;
        bus.cc = 3'd0;
        bus.flags = 8'd0;
        bus.reg_a = 8'd0;
        bus.mem_ack = 1'b0;
        bus.mem_data = 8'd0;
        bus.io_ack = 1'b0;
        bus.io_rdata = 8'd0;
        tick;
        tick;
        check("reset_state", all_outs(), 64'd0);
        reset = 1'b0;
        tick;
        check("idle_after_reset", all_outs(), 64'd0);

        do_jp(1'b1, 3'd0, 8'h00, 8'h34, 8'h12, 0, 1'b1, 1'b0);
        do_jp(1'b0, 3'd1, 8'h00, 8'hCD, 8'hAB, 0, 1'b0, 1'b0);
        do_jp(1'b0, 3'd1, 8'h40, 8'hCD, 8'hAB, 0, 1'b1, 1'b0);
        do_jp(1'b1, 3'd5, 8'h00, 8'h78, 8'h56, 2, 1'b1, 1'b0);
        do_io(1'b1, 8'h77, 8'h5A, 8'h00, 3);
        do_io(1'b0, 8'h02, 8'h10, 8'hC3, 1);
        do_io(1'b0, 8'hFF, 8'h00, 8'h00, 0);

        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        check("no_class_ignored", {62'd0, bus.busy, bus.mem_req}, 64'd0);
        bus.start = 1'b1;
        {bus.set_jpnn, bus.set_jpcc, bus.set_out_n_a, bus.set_in_a_n} = 4'b1001;
        tick;
        bus.start = 1'b0;
        {bus.set_jpnn, bus.set_jpcc, bus.set_out_n_a, bus.set_in_a_n} = 4'b0000;
        check("two_class_ignored", {62'd0, bus.busy, bus.mem_req}, 64'd0);
        tick;

        sb.push_back(ev(EV_INC, 32'd0));
        issue(4'b1000, 3'd0, 8'h00, 8'h00);
        mem_byte(8'h11, 0);
        reset = 1'b1;
        bus.mem_ack = 1'b1;
        bus.mem_data = 8'h22;
        #1;
        check("reset_mid_outputs", all_outs(), 64'd0);
        tick;
        reset = 1'b0;
        tick;
        check("ack_after_reset_ignored", all_outs(), 64'd0);
        bus.mem_ack = 1'b0;
        tick;
        check("reset_sb_drained", 64'(sb.size()), 64'd0);
        do_jp(1'b1, 3'd0, 8'h00, 8'hEF, 8'hBE, 0, 1'b1, 1'b0);

        for (int c = 0; c < 8; c++) begin
            for (int k = 0; k < 16; k++) begin
                f = (8'($urandom) & 8'h3A) | {k[3], k[2], 3'b000, k[1], 1'b0, k[0]};
                case (c)
                    0: exp = ~f[6];
                    1: exp = f[6];
                    2: exp = ~f[0];
                    3: exp = f[0];
                    4: exp = ~f[2];
                    5: exp = f[2];
                    6: exp = ~f[7];
                    default: exp = f[7];
                endcase
                do_jp(1'b0, 3'(c), f, 8'($urandom), 8'($urandom), 0, exp, k == 5);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
